// File: rtl/sddac_mc_pkg.sv
// Shared constants and helpers for the multichannel sigma-delta DAC.
package sddac_mc_pkg;

    localparam int SDDAC_ORDER_1 = 1;
    localparam int SDDAC_ORDER_2 = 2;

    // Selects the feedback level from the previous output bit.
    typedef enum logic {
        FB_NEG = 1'b0,
        FB_POS = 1'b1
    } fb_e;

    // Width of the integrator feeding the output comparator for a given order:
    // i1 is SMP_W+2 bits and i2 is SMP_W+4 bits.
    function automatic int integ_width(input int smp_w, input int order);
        return smp_w + 2 * order;
    endfunction

    // Full-scale magnitude 2^(SMP_W-1).
    function automatic longint full_scale(input int smp_w);
        return longint'(1) <<< (smp_w - 1);
    endfunction

endpackage

// File: rtl/sddac_mod_ch.sv
// One channel: linear interpolator feeding a 1st/2nd order sigma-delta modulator.
module sddac_mod_ch
    import sddac_mc_pkg::*;
#(
    parameter int SMP_W     = 18,
    parameter int ORDER     = 2,
    parameter int INTERP_SH = 8
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    tick,
    input  logic                    capture,
    input  logic signed [SMP_W-1:0] sample,
    output logic                    dac_out,
    output logic                    busy
);

    localparam int ACC_W = SMP_W + INTERP_SH + 1;
    localparam int I1_W  = integ_width(SMP_W, SDDAC_ORDER_1);
    localparam int I2_W  = integ_width(SMP_W, SDDAC_ORDER_2);
    // Headroom so integrator + input + feedback never overflows before clamping.
    localparam int SUM_W = SMP_W + 6;
    localparam int CNT_W = INTERP_SH + 1;

    localparam logic [CNT_W-1:0] RAMP_LEN = CNT_W'(1) << INTERP_SH;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic signed [SUM_W-1:0] FS_P   = {{(SUM_W-SMP_W){1'b0}}, 1'b1, {(SMP_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] FS_N   = {{(SUM_W-SMP_W+1){1'b1}}, {(SMP_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] I1_MAX = {{(SUM_W-I1_W+1){1'b0}}, {(I1_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] I1_MIN = {{(SUM_W-I1_W+1){1'b1}}, {(I1_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] I2_MAX = {{(SUM_W-I2_W+1){1'b0}}, {(I2_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] I2_MIN = {{(SUM_W-I2_W+1){1'b1}}, {(I2_W-1){1'b0}}};

    logic signed [ACC_W-1:0] r_acc;
    logic signed [SMP_W-1:0] r_target;
    logic signed [SMP_W:0]   r_step;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [I1_W-1:0]  r_i1;
    logic signed [I2_W-1:0]  r_i2;
    logic                    r_dac;

    logic signed [SMP_W-1:0] w_x;
    logic signed [SUM_W-1:0] w_fb;
    logic signed [SUM_W-1:0] w_i1_sum;
    logic signed [SUM_W-1:0] w_i2_sum;
    logic signed [I1_W-1:0]  w_i1_nxt;
    logic signed [I2_W-1:0]  w_i2_nxt;
    logic                    w_dac_nxt;
    logic signed [ACC_W-1:0] w_acc_step;
    logic signed [ACC_W-1:0] w_acc_snap;

    // acc >>> INTERP_SH truncated to SMP_W bits is exactly this bit slice.
    assign w_x = r_acc[INTERP_SH +: SMP_W];

    assign w_fb = (fb_e'(r_dac) == FB_POS) ? FS_P : FS_N;

    assign w_i1_sum = {{(SUM_W-I1_W){r_i1[I1_W-1]}}, r_i1}
                    + {{(SUM_W-SMP_W){w_x[SMP_W-1]}}, w_x}
                    - w_fb;
    assign w_i1_nxt = (w_i1_sum > I1_MAX) ? I1_MAX[I1_W-1:0] :
                      (w_i1_sum < I1_MIN) ? I1_MIN[I1_W-1:0] :
                                            w_i1_sum[I1_W-1:0];

    // Second stage integrates the already-updated i1.
    assign w_i2_sum = {{(SUM_W-I2_W){r_i2[I2_W-1]}}, r_i2}
                    + {{(SUM_W-I1_W){w_i1_nxt[I1_W-1]}}, w_i1_nxt}
                    - w_fb;
    assign w_i2_nxt = (w_i2_sum > I2_MAX) ? I2_MAX[I2_W-1:0] :
                      (w_i2_sum < I2_MIN) ? I2_MIN[I2_W-1:0] :
                                            w_i2_sum[I2_W-1:0];

    assign w_dac_nxt = (ORDER == SDDAC_ORDER_1) ? ~w_i1_nxt[I1_W-1] : ~w_i2_nxt[I2_W-1];

    assign w_acc_step = r_acc + {{(ACC_W-SMP_W-1){r_step[SMP_W]}}, r_step};
    assign w_acc_snap = {r_target[SMP_W-1], r_target, {INTERP_SH{1'b0}}};

    assign busy    = (r_cnt != '0);
    assign dac_out = r_dac;

    // Interpolator and modulator state; a capture takes priority over a tick for acc.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_target <= '0;
            r_step   <= '0;
            r_cnt    <= '0;
            r_i1     <= '0;
            r_i2     <= '0;
            r_dac    <= 1'b0;
        end else if (!en) begin
            // Disabled: datapath and any ramp in flight are dropped, target/step kept.
            r_acc <= '0;
            r_cnt <= '0;
            r_i1  <= '0;
            r_i2  <= '0;
            r_dac <= 1'b0;
        end else begin
            if (tick) begin
                r_i1  <= w_i1_nxt;
                if (ORDER == SDDAC_ORDER_2)
                    r_i2 <= w_i2_nxt;
                r_dac <= w_dac_nxt;
            end
            if (capture) begin
                // Overrun: finish the old ramp instantly so the new one starts from its end.
                if (busy)
                    r_acc <= w_acc_snap;
                r_step   <= {sample[SMP_W-1], sample} - {r_target[SMP_W-1], r_target};
                r_target <= sample;
                r_cnt    <= RAMP_LEN;
            end else if (tick && busy) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/sddac_mc.sv
// Multichannel sigma-delta DAC: shared tick divider, overrun flag and per-channel modulators.
module sddac_mc
    import sddac_mc_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int SMP_W     = 18,
    parameter int ORDER     = 2,
    parameter int DIV       = 8,
    parameter int INTERP_SH = 8
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      sample_in_rdy,
    input  logic [CHANNELS*SMP_W-1:0] sample_in,
    output logic [CHANNELS-1:0]       dac_out,
    output logic                      ramp_busy,
    output logic                      overrun
);

    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    generate
        if (ORDER != SDDAC_ORDER_1 && ORDER != SDDAC_ORDER_2) begin : g_bad_order
            $error("sddac_mc: ORDER must be 1 or 2");
        end
        if (DIV < 2) begin : g_bad_div
            $error("sddac_mc: DIV must be >= 2");
        end
    endgenerate

    logic [DIV_W-1:0]                r_div;
    logic                            r_overrun;
    logic                            w_tick;
    logic                            w_capture;
    logic [CHANNELS-1:0]             w_busy;
    logic [CHANNELS-1:0][SMP_W-1:0]  w_smp;

    assign w_tick    = en && (r_div == DIV_LAST);
    assign w_capture = en && sample_in_rdy;
    assign w_smp     = sample_in;
    assign ramp_busy = |w_busy;
    assign overrun   = r_overrun;

    // Modulator step divider: free-runs 0..DIV-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (reset || !en)
            r_div <= '0;
        else if (w_tick)
            r_div <= '0;
        else
            r_div <= r_div + DIV_ONE;
    end

    // One-cycle overrun pulse for a sample landing on an unfinished ramp.
    always_ff @(posedge clk) begin
        if (reset)
            r_overrun <= 1'b0;
        else
            r_overrun <= w_capture && ramp_busy;
    end

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
            sddac_mod_ch #(
                .SMP_W     (SMP_W),
                .ORDER     (ORDER),
                .INTERP_SH (INTERP_SH)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .en      (en),
                .tick    (w_tick),
                .capture (w_capture),
                .sample  (w_smp[k]),
                .dac_out (dac_out[k]),
                .busy    (w_busy[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sddac_mc.sv
// Bench for sddac_mc: ORDER=1 and ORDER=2 instances driven in parallel against a behavioural model.
module tb_sddac_mc;

    localparam int  CH  = 2;
    localparam int  W   = 18;
    localparam int  DIV = 8;
    localparam int  SH  = 8;
    localparam longint FS = 131072;
    localparam int  RAMP = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic              sample_in_rdy = 1'b0;
    logic [CH*W-1:0]   sample_in = '0;
    logic [CH-1:0]     dac1, dac2;
    logic              busy1, busy2, ovr1, ovr2;

    int nvec = 0;
    int nerr = 0;

    // Behavioural model state; order index 0 is ORDER=1, 1 is ORDER=2.
    int     mdiv;
    bit     mtick;
    bit     movr;
    longint macc [CH];
    longint mtgt [CH];
    longint mstp [CH];
    int     mcnt [CH];
    longint mi1 [2][CH];
    longint mi2 [2][CH];
    bit     mdac [2][CH];

    always #5 clk = ~clk;

    sddac_mc #(.CHANNELS(CH), .SMP_W(W), .ORDER(1), .DIV(DIV), .INTERP_SH(SH)) u_o1 (
        .clk(clk), .reset(reset), .en(en), .sample_in_rdy(sample_in_rdy),
        .sample_in(sample_in), .dac_out(dac1), .ramp_busy(busy1), .overrun(ovr1));

    sddac_mc #(.CHANNELS(CH), .SMP_W(W), .ORDER(2), .DIV(DIV), .INTERP_SH(SH)) u_o2 (
        .clk(clk), .reset(reset), .en(en), .sample_in_rdy(sample_in_rdy),
        .sample_in(sample_in), .dac_out(dac2), .ramp_busy(busy2), .overrun(ovr2));

    function automatic longint wrapw(input longint v, input int b);
        return (v <<< (64 - b)) >>> (64 - b);
    endfunction

    function automatic longint clampv(input longint v, input int b);
        longint mx;
        mx = (longint'(1) <<< (b - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    function automatic logic [CH*W-1:0] pk(input int a, input int b);
        logic [31:0] ua, ub;
        ua = a;
        ub = b;
        return {ub[W-1:0], ua[W-1:0]};
    endfunction

    function automatic logic [CH*W-1:0] rnd();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[CH*W-1:0];
    endfunction

    // Advance the model across one clock edge using the spec's rules.
    task automatic model_edge(input bit r, input bit e, input bit rdy, input logic [CH*W-1:0] s);
        bit busy_old;
        longint x, fb, smp;
        logic [W-1:0] sl;
        if (r || !e) begin
            mdiv = 0; mtick = 0; movr = 0;
            for (int c = 0; c < CH; c++) begin
                macc[c] = 0; mcnt[c] = 0;
                if (r) begin mtgt[c] = 0; mstp[c] = 0; end
                for (int o = 0; o < 2; o++) begin mi1[o][c] = 0; mi2[o][c] = 0; mdac[o][c] = 0; end
            end
            return;
        end
        mtick = (mdiv == DIV - 1);
        mdiv  = mtick ? 0 : mdiv + 1;
        busy_old = 0;
        for (int c = 0; c < CH; c++) if (mcnt[c] != 0) busy_old = 1;
        for (int c = 0; c < CH; c++) begin
            if (mtick) begin
                x = wrapw(macc[c] >>> SH, W);
                for (int o = 0; o < 2; o++) begin
                    fb = mdac[o][c] ? FS : -FS;
                    mi1[o][c] = clampv(mi1[o][c] + x - fb, W + 2);
                    if (o == 1) mi2[o][c] = clampv(mi2[o][c] + mi1[o][c] - fb, W + 4);
                    mdac[o][c] = (o == 0) ? (mi1[o][c] >= 0) : (mi2[o][c] >= 0);
                end
            end
            if (rdy) begin
                sl = s[c*W +: W];
                smp = longint'($signed(sl));
                if (mcnt[c] != 0) macc[c] = mtgt[c] <<< SH;
                mstp[c] = smp - mtgt[c];
                mtgt[c] = smp;
                mcnt[c] = RAMP;
            end else if (mtick && mcnt[c] > 0) begin
                macc[c] = wrapw(macc[c] + mstp[c], W + SH + 1);
                mcnt[c]--;
            end
        end
        movr = rdy && busy_old;
    endtask

    task automatic check_model();
        logic [CH-1:0] e1, e2;
        bit eb;
        eb = 0;
        for (int c = 0; c < CH; c++) begin
            e1[c] = mdac[0][c];
            e2[c] = mdac[1][c];
            if (mcnt[c] != 0) eb = 1;
        end
        nvec++; if (dac1 !== e1) begin nerr++; $display("FAIL dac_o1 t=%0t got=%b exp=%b", $time, dac1, e1); end
        nvec++; if (dac2 !== e2) begin nerr++; $display("FAIL dac_o2 t=%0t got=%b exp=%b", $time, dac2, e2); end
        nvec++; if (busy1 !== eb) begin nerr++; $display("FAIL busy_o1 t=%0t got=%b exp=%b", $time, busy1, eb); end
        nvec++; if (busy2 !== eb) begin nerr++; $display("FAIL busy_o2 t=%0t got=%b exp=%b", $time, busy2, eb); end
        nvec++; if (ovr1 !== movr) begin nerr++; $display("FAIL ovr_o1 t=%0t got=%b exp=%b", $time, ovr1, movr); end
        nvec++; if (ovr2 !== movr) begin nerr++; $display("FAIL ovr_o2 t=%0t got=%b exp=%b", $time, ovr2, movr); end
    endtask

    // One clock: drive inputs, step model at the edge, sample outputs 1ns later.
    task automatic cyc(input bit r, input bit e, input bit rdy, input logic [CH*W-1:0] s);
        reset = r; en = e; sample_in_rdy = rdy; sample_in = s;
        @(posedge clk);
        model_edge(r, e, rdy, s);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
    endtask

    // Run until n modulator ticks have happened, counting ch0 ones and ramp_busy cycles.
    task automatic ticks(input int n, output int ones1, output int ones2, output int busyc);
        int t;
        t = 0; ones1 = 0; ones2 = 0; busyc = 0;
        while (t < n) begin
            cyc(0, 1, 0, rnd());
            if (busy1) busyc++;
            if (mtick) begin
                t++;
                ones1 += int'(dac1[0]);
                ones2 += int'(dac2[0]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (dac1 !== 2'b00 || dac2 !== 2'b00) begin nerr++; $display("FAIL reset_dac got=%b/%b exp=00", dac1, dac2); end
        nvec++; if (busy1 !== 1'b0 || ovr1 !== 1'b0) begin nerr++; $display("FAIL reset_flags busy=%b ovr=%b exp=0", busy1, ovr1); end
        for (int i = 0; i < 100; i++) begin
            cyc(0, 0, ($urandom_range(0, 1) == 1), rnd());
            nvec++;
            if (dac1 !== 2'b00 || dac2 !== 2'b00 || busy1 || busy2 || ovr1 || ovr2) begin
                nerr++; $display("FAIL en_low_idle i=%0d dac=%b/%b busy=%b ovr=%b exp all 0", i, dac1, dac2, busy1, ovr1);
            end
        end
    endtask

    task automatic test_zero();
        int o1, o2, bc;
        do_reset();
        cyc(0, 1, 1, pk(0, 0));
        ticks(RAMP, o1, o2, bc);
        nvec++; if (o1 < 127 || o1 > 129) begin nerr++; $display("FAIL zero_density_o1 ones=%0d exp=127..129", o1); end
        nvec++; if (dac1[0] !== dac1[1]) begin nerr++; $display("FAIL zero_ch_match got=%b exp equal bits", dac1); end
    endtask

    task automatic test_full_scale();
        int o1, o2, bc;
        do_reset();
        cyc(0, 1, 1, pk(131071, 131071));
        ticks(RAMP, o1, o2, bc);
        nvec++; if (busy2 !== 1'b0) begin nerr++; $display("FAIL fs_pos_ramp_done busy=%b exp=0", busy2); end
        ticks(2 * RAMP, o1, o2, bc);
        ticks(RAMP, o1, o2, bc);
        nvec++; if (o2 < 255) begin nerr++; $display("FAIL fs_pos_density ones=%0d exp>=255", o2); end
        do_reset();
        cyc(0, 1, 1, pk(-131072, -131072));
        ticks(3 * RAMP, o1, o2, bc);
        ticks(RAMP, o1, o2, bc);
        nvec++; if (o2 > 1) begin nerr++; $display("FAIL fs_neg_density ones=%0d exp<=1", o2); end
    endtask

    task automatic test_ramp();
        int o1, o2, bc, tot;
        do_reset();
        cyc(0, 1, 0, '0);
        cyc(0, 1, 0, '0);
        cyc(0, 1, 1, pk(1024, 1024));
        tot = int'(busy1);
        ticks(RAMP, o1, o2, bc);
        tot += bc;
        nvec++; if (tot < 255 * DIV + 1 || tot > 256 * DIV) begin nerr++; $display("FAIL ramp_busy_len cycles=%0d exp=%0d..%0d", tot, 255*DIV+1, 256*DIV); end
        nvec++; if (busy1 !== 1'b0) begin nerr++; $display("FAIL ramp_busy_fall busy=%b exp=0", busy1); end
        ticks(RAMP, o1, o2, bc);
        nvec++; if (o1 < 128 || o1 > 130) begin nerr++; $display("FAIL ramp_density_o1 ones=%0d exp=128..130", o1); end
    endtask

    task automatic test_overrun();
        int o1, o2, bc, tot;
        do_reset();
        cyc(0, 1, 1, pk(1000, 1000));
        ticks(100, o1, o2, bc);
        cyc(0, 1, 1, pk(-1000, -1000));
        nvec++; if (ovr1 !== 1'b1 || ovr2 !== 1'b1) begin nerr++; $display("FAIL overrun_pulse got=%b/%b exp=1", ovr1, ovr2); end
        tot = int'(busy1);
        cyc(0, 1, 0, '0);
        tot += int'(busy1);
        nvec++; if (ovr1 !== 1'b0) begin nerr++; $display("FAIL overrun_width got=%b exp=0", ovr1); end
        ticks(RAMP, o1, o2, bc);
        tot += bc;
        nvec++; if (tot < 255 * DIV + 1 || tot > 256 * DIV) begin nerr++; $display("FAIL overrun_ramp_len cycles=%0d exp=%0d..%0d", tot, 255*DIV+1, 256*DIV); end
    endtask

    task automatic test_collide();
        int o1, o2, bc;
        do_reset();
        cyc(0, 1, 1, pk(500, -500));
        ticks(20, o1, o2, bc);
        for (int k = 0; k < DIV && mdiv != DIV - 1; k++) cyc(0, 1, 0, rnd());
        cyc(0, 1, 1, pk(3000, -3000));
        ticks(10, o1, o2, bc);
        cyc(0, 0, 0, rnd());
        nvec++; if (dac1 !== 2'b00 || dac2 !== 2'b00) begin nerr++; $display("FAIL en_drop_dac got=%b/%b exp=00", dac1, dac2); end
        nvec++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin nerr++; $display("FAIL en_drop_busy got=%b/%b exp=0", busy1, busy2); end
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, rnd());
        ticks(40, o1, o2, bc);
        cyc(0, 1, 1, pk(-2000, 7000));
        ticks(RAMP + 4, o1, o2, bc);
    endtask

    task automatic test_random();
        int gap;
        do_reset();
        for (int it = 0; it < 20; it++) begin
            cyc(0, 1, 1, rnd());
            gap = $urandom_range(1, 1500);
            for (int i = 0; i < gap; i++) cyc(0, 1, 0, rnd());
            if ($urandom_range(0, 5) == 0)
                for (int i = 0; i < 4; i++) cyc(0, 0, ($urandom_range(0, 1) == 1), rnd());
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_full_scale();
        test_ramp();
        test_overrun();
        test_collide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
